// File: rtl/gray_codec_pkg.sv
// Shared types and elaboration helpers for the gray_codec pipeline.
package gray_codec_pkg;

  typedef enum logic {
    DIR_G2B = 1'b0,
    DIR_B2G = 1'b1
  } dir_e;

  localparam int unsigned STATS_W = 32;

  // Number of prefix-XOR stages needed to fully decode a word of the given width.
  function automatic int unsigned num_steps(input int unsigned width);
    int unsigned s;
    s = $clog2(width);
    return (s < 1) ? 1 : s;
  endfunction

  // A zero or oversized bit count selects the full lane width.
  function automatic int unsigned clamp_bits(input int unsigned bits, input int unsigned width);
    return ((bits == 0) || (bits > width)) ? width : bits;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One prefix-XOR pipeline register: applies x ^ (x >> SHIFT) per lane for Gray->binary beats.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned SHIFT      = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_en,
  input  logic                                   i_valid,
  input  dir_e                                   i_dir,
  input  logic                                   i_last,
  input  logic [$clog2(DATA_WIDTH + 1)-1:0]      i_bits,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]        i_data,
  output logic                                   o_valid,
  output dir_e                                   o_dir,
  output logic                                   o_last,
  output logic [$clog2(DATA_WIDTH + 1)-1:0]      o_bits,
  output logic [NUM_LANES*DATA_WIDTH-1:0]        o_data
);

  localparam int unsigned BITS_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned W      = NUM_LANES * DATA_WIDTH;

  logic [W-1:0]      w_next;
  logic [W-1:0]      r_data;
  logic              r_valid;
  dir_e              r_dir;
  logic              r_last;
  logic [BITS_W-1:0] r_bits;

  always_comb begin
    w_next = i_data;
    if (i_dir == DIR_G2B) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        w_next[l*DATA_WIDTH +: DATA_WIDTH] =
          i_data[l*DATA_WIDTH +: DATA_WIDTH] ^ (i_data[l*DATA_WIDTH +: DATA_WIDTH] >> SHIFT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_dir   <= DIR_G2B;
      r_last  <= 1'b0;
      r_bits  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_next;
      r_dir   <= i_dir;
      r_last  <= i_last;
      r_bits  <= i_bits;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dir   = r_dir;
  assign o_last  = r_last;
  assign o_bits  = r_bits;

endmodule

// File: rtl/gray_codec.sv
// Multi-lane pipelined Gray<->binary converter with valid/ready flow control.
// Defining GRAY_CODEC_STATS_EN adds a saturating output-handshake counter on o_beat_count.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned BITS_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_dir,
  input  logic [BITS_W-1:0]               i_bits,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] i_data,
  input  logic                            i_last,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] o_data,
`ifdef GRAY_CODEC_STATS_EN
  output logic [STATS_W-1:0]              o_beat_count,
`endif
  output logic                            o_last
);

  localparam int unsigned N = num_steps(DATA_WIDTH);
  localparam int unsigned W = NUM_LANES * DATA_WIDTH;

  logic                  w_en;
  int unsigned           w_nbits;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [W-1:0]          w_r0_next;

  logic [W-1:0]          r_data0;
  logic                  r_valid0;
  dir_e                  r_dir0;
  logic                  r_last0;
  logic [BITS_W-1:0]     r_bits0;

  logic [W-1:0]          w_data  [0:N];
  logic                  w_valid [0:N];
  dir_e                  w_dir   [0:N];
  logic                  w_last  [0:N];
  logic [BITS_W-1:0]     w_bits  [0:N];
  logic                  w_unused_tail;

  // Single global enable: the whole pipe stalls together, bubbles included.
  assign w_en    = ~o_valid | i_ready;
  assign o_ready = w_en;

  always_comb begin
    logic [DATA_WIDTH-1:0] v_lane;
    w_r0_next = '0;
    v_lane    = '0;
    w_nbits   = clamp_bits(32'(i_bits), DATA_WIDTH);
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_mask[i] = (i < w_nbits);
    end
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      v_lane = i_data[l*DATA_WIDTH +: DATA_WIDTH] & w_mask;
      w_r0_next[l*DATA_WIDTH +: DATA_WIDTH] =
        (dir_e'(i_dir) == DIR_B2G) ? (v_lane ^ (v_lane >> 1)) : v_lane;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid0 <= 1'b0;
      r_data0  <= '0;
      r_dir0   <= DIR_G2B;
      r_last0  <= 1'b0;
      r_bits0  <= '0;
    end else if (w_en) begin
      r_valid0 <= i_valid;
      r_data0  <= w_r0_next;
      r_dir0   <= dir_e'(i_dir);
      r_last0  <= i_last;
      r_bits0  <= BITS_W'(w_nbits);
    end
  end

  assign w_data[0]  = r_data0;
  assign w_valid[0] = r_valid0;
  assign w_dir[0]   = r_dir0;
  assign w_last[0]  = r_last0;
  assign w_bits[0]  = r_bits0;

  for (genvar k = 1; k <= N; k++) begin : g_stage
    gray_codec_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_LANES  (NUM_LANES),
      .SHIFT      (1 << (k - 1))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_valid[k-1]),
      .i_dir   (w_dir[k-1]),
      .i_last  (w_last[k-1]),
      .i_bits  (w_bits[k-1]),
      .i_data  (w_data[k-1]),
      .o_valid (w_valid[k]),
      .o_dir   (w_dir[k]),
      .o_last  (w_last[k]),
      .o_bits  (w_bits[k]),
      .o_data  (w_data[k])
    );
  end

  assign o_valid = w_valid[N];
  assign o_data  = w_data[N];
  assign o_last  = w_last[N];

  // Direction and bit count are only consumed by the stages; the tail copies are dropped.
  assign w_unused_tail = ^{w_bits[N], w_dir[N]};

`ifdef GRAY_CODEC_STATS_EN
  logic [STATS_W-1:0] r_beat_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_count <= '0;
    end else if (o_valid && i_ready && (r_beat_count != '1)) begin
      r_beat_count <= r_beat_count + 1'b1;
    end
  end

  assign o_beat_count = r_beat_count;
`endif

endmodule

// File: doc/gray_codec.md
# gray_codec

Multi-lane, pipelined, bidirectional Gray/binary converter for the constellation mapper/demapper path. Each beat carries `NUM_LANES` words (I/Q by default) and a per-beat direction and active bit count, so square QAM orders from 4 to 2^(2·DATA_WIDTH) share one instance. Conversion uses a log-step prefix-XOR pipeline with valid/ready backpressure. The block sits between the symbol packer and the mapper LUT, or between the slicer and the bit unpacker.

## Interface
- `DATA_WIDTH`, default 16: bits per lane word; minimum 2.
- `NUM_LANES`, default 2: independent lanes converted in parallel, all with identical control.
- `BITS_W`, default `$clog2(DATA_WIDTH+1)`: width of `i_bits`; derived, do not override.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: upstream beat valid.
- `o_ready`, out, 1: block accepts a beat in this cycle.
- `i_dir`, in, 1: 0 = Gray→binary, 1 = binary→Gray.
- `i_bits`, in, `BITS_W`: active LSBs per lane (bits per lane per symbol).
- `i_data`, in, `NUM_LANES*DATA_WIDTH`: lane 0 in the LSBs.
- `i_last`, in, 1: frame marker, passed through unchanged.
- `o_valid`, out, 1: output beat valid.
- `i_ready`, in, 1: downstream accepts a beat.
- `o_data`, out, `NUM_LANES*DATA_WIDTH`: converted words.
- `o_last`, out, 1: delayed `i_last`.
- `o_beat_count`, out, 32: present only with `GRAY_CODEC_STATS_EN`.

## Operation
- A handshake occurs when `i_valid & o_ready`. Direction, bit count and last marker travel with the beat, so mixed directions on back-to-back beats are legal.
- `N = max(1, $clog2(DATA_WIDTH))`. The pipeline has registers R0..RN.
- **R0 (capture):**
  - Clamp the bit count: `i_bits` of 0 or greater than `DATA_WIDTH` is treated as `DATA_WIDTH`.
  - Zero every lane bit at or above the clamped count.
  - If `i_dir` = 1, compute `g = b ^ (b >> 1)` on the masked word.
- **Rk, for k = 1..N:** for Gray→binary beats, `x = x ^ (x >> 2^(k-1))`; for binary→Gray beats, pass the word unchanged. Shifts are logical, within the lane.
- `o_data` = RN data. Upper bits are always zero because masking precedes conversion.
- **Flow control:** a global advance enable `en = ~o_valid | i_ready`, and `o_ready = en`.
  - While `en` = 0, every stage holds data, valid and sideband.
  - Bubbles are not collapsed; this is a fixed-stall pipeline.
- **Per-stage valid:** each stage has a valid bit, shifted with `en`. `o_valid` = valid of RN.
- **Reset (asynchronous):** all valids, data, sideband and the counter clear immediately.
  - Reset values: `o_valid` = 0, `o_data` = 0, `o_last` = 0, `o_beat_count` = 0.
  - `o_ready` = 1 in the first cycle after release.
  - Beats in flight at reset are discarded; no partial output is produced.

## Timing
- Latency: a handshake in cycle 0 gives `o_valid` in cycle N+1 when there is no stall. For `DATA_WIDTH` = 16, N = 4 and latency is 5 cycles.
- Throughput: one beat per clock while `i_ready` = 1.
- `o_ready` is combinational from `o_valid` and `i_ready` only. It has no path from `i_valid`.
- If `i_ready` drops while `o_valid` = 1, `o_data` and `o_last` stay stable until the next edge at which `i_ready` = 1.
- `i_valid` may assert while `o_ready` = 0. The beat is taken on the first cycle in which `o_ready` = 1; upstream must hold its data until then.

## Configuration
- `GRAY_CODEC_STATS_EN` defined:
  - Adds the `o_beat_count` port, a 32-bit counter incremented on each output handshake (`o_valid & i_ready`).
  - The counter saturates at 0xFFFF_FFFF and clears only on reset.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- **`gray_codec_pkg` contains:**
  - the `dir_e` enum (`DIR_G2B` = 0, `DIR_B2G` = 1);
  - the function `num_steps(width)`;
  - the function `clamp_bits(bits, width)`.
- **Sub-module `gray_codec_stage`:** one pipeline register holding data, valid, dir, last and bits.
  - Parameters: `DATA_WIDTH`, `NUM_LANES`, `SHIFT`.
  - Applies its prefix-XOR step when dir = `DIR_G2B`.
  - Instantiated N times in a generate loop; R0 is coded in the top level.

## Test plan
- **Gray→binary, full width:** `DATA_WIDTH` = 16, `i_dir` = 0, `i_bits` = 16, lane0 = 0x8000, lane1 = 0x0003 → lane0 = 0xFFFF, lane1 = 0x0002, with `o_valid` 5 cycles after the handshake.
- **Binary→Gray and masking:**
  - `i_dir` = 1, `i_bits` = 3, lane0 = 0x0005 → 0x0007.
  - `i_dir` = 0, `i_bits` = 4, lane0 = 0xFFFF → 0x000A.
  - `i_bits` = 0 behaves as 16.
- **Backpressure:**
  - Stream 20 random beats with mixed direction.
  - Toggle `i_ready` with a 40% low pattern.
  - Expected: every output matches the reference model, in order, with none lost or duplicated; `o_data` is stable while stalled; `o_last` is aligned with its beat.
- **Full throughput:** hold `i_ready` = 1 and `i_valid` = 1 for 100 beats → 100 outputs on consecutive cycles, and `o_ready` never drops.
- **Reset mid-stream:**
  - Assert `rst` = 0 with 3 beats in flight → `o_valid` and `o_data` go to 0 asynchronously.
  - After release, no stale beat appears and the first new beat has 5-cycle latency.
- **`GRAY_CODEC_STATS_EN`:**
  - 10 output handshakes plus 4 stalled cycles → `o_beat_count` = 10.
  - Force the counter to 0xFFFF_FFFE, then 3 handshakes → it holds at 0xFFFF_FFFF.
